axi_addr_remapper: RTL and testbench
====================================

# axi_addr_remapper

Parametrised AXI4 address remapper between the core's memory master port and the SoC memory slave port. It is the next generation of the fixed single-window address mapper.
- Translates each AW/AR address through up to NUM_REGIONS base/mask/target windows, first match wins.
- Registers the AW and AR channels.
- Completes unmapped transactions locally with DECERR instead of forwarding them.
- Keeps response ordering by counting outstanding downstream transactions.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width of both ports
- DATA_WIDTH, 64, data width (W/R pass through unchanged)
- ID_WIDTH, 1, AXI ID width
- NUM_REGIONS, 4, number of translation windows, 1..8
- OUTST_WIDTH, 4, width of per-direction outstanding counters (max 2^OUTST_WIDTH-1 in flight)

Ports:
- uncoreclk  in  1  sole clock
- uncorersts  in  1  synchronous active-high reset
- cfg_base  in  NUM_REGIONS*ADDR_WIDTH  window base, region i at slice i
- cfg_mask  in  NUM_REGIONS*ADDR_WIDTH  window mask; 1 bits are the offset bits kept from the incoming address
- cfg_target  in  NUM_REGIONS*ADDR_WIDTH  replacement for the non-offset bits
- cfg_en  in  NUM_REGIONS  per-region enable
- s_axi_aw{id,addr,len,size,burst,valid}/awready, w{data,strb,last,valid}/wready, b{id,resp,valid}/bready, ar{id,addr,len,size,burst,valid}/arready, r{id,data,resp,last,valid}/rready  AXI4 slave from the core
- m_axi_* with the identical field set  AXI4 master to the SoC

## Operation
- Match rule: region i hits when cfg_en[i] and (addr & ~mask_i) == (base_i & ~mask_i). The lowest hit index wins.
- Translation: out_addr = (addr & mask_i) | (target_i & ~mask_i). All other AW/AR fields pass unchanged.
- cfg_* is sampled in the cycle the AW/AR handshake occurs. Changing cfg_* later does not affect accepted transactions.
- AW/AR slices: one-entry register per channel.
  - s_awready = slice empty and write-data phase idle.
  - Same rule for AR, without the data-phase term.
- Write routing FSM:
  - W_IDLE: on AW accept, go to W_FWD if mapped, else W_SINK.
  - W_FWD: W beats pass combinationally s<->m. WLAST handshake returns to W_IDLE.
  - W_SINK: s_wready=1 and beats are discarded. WLAST handshake moves to W_ERRB.
  - W_ERRB: wait until wr_outst==0, then drive s_bvalid with the captured id and resp=2'b11. The handshake returns to W_IDLE.
  - No new AW is accepted outside W_IDLE.
- Read error FSM:
  - R_IDLE: on an unmapped AR, capture id/len and go to R_WAIT.
  - R_WAIT: wait until rd_outst==0, then go to R_ERR.
  - R_ERR: drive len+1 beats of rdata=0, rresp=2'b11, rlast on the final beat. The last handshake returns to R_IDLE.
  - No AR is accepted outside R_IDLE.
- B/R muxing: the error path owns s_b*/s_r* only in W_ERRB/R_ERR. Otherwise m_b*/m_r* pass through. m_bready/m_rready are forced 0 while the error path owns the channel.
- Outstanding counters:
  - wr_outst increments on m_aw handshake and decrements on m_b handshake.
  - rd_outst increments on m_ar handshake and decrements on m_r handshake with rlast.
  - A simultaneous increment and decrement leaves the counter unchanged.
  - At max count, the slice holds m_*valid asserted (no upstream accept) until the count drops.

## Timing
- Reset values: all s_*ready and m_*valid = 0, s_bvalid = s_rvalid = 0, counters = 0, FSMs in *_IDLE. s_awready and s_arready rise on the first cycle after reset deasserts.
- Mapped AW/AR: handshake in cycle N gives m_*valid in N+1. The slice empties on the m handshake and can re-accept in the same cycle.
- W/B/R forward path: zero added latency.
- Error read: first beat no earlier than 1 cycle after AR accept (R_WAIT is at least 1 cycle). Beats then run back-to-back under rready.
- Error write: s_bvalid no earlier than 1 cycle after the WLAST handshake.
- Reset mid-burst discards all state. Downstream stranded beats are the system's responsibility.

## Structure
- axi_remap_pkg holds:
  - the AXI resp encodings (OKAY=2'b00, DECERR=2'b11)
  - the W-FSM and R-FSM state enums
  - the region-match function
- Sub-module axi_remap_slice is one-entry valid/ready register, instantiated for AW and AR.

## Test plan
- Region 0 base 0x0000_0000, mask 0x0FFF_FFFF, target 0x1000_0000; AR addr 0x0000_1000 len 3 -> m_araddr 0x1000_1000 one cycle later; 4 R beats pass through unchanged.
- Regions 0 and 1 overlap, both enabled; AW hits both -> region 0 translation used. Disable region 0 -> region 1 used.
- Unmapped AW len 7 -> 8 W beats absorbed, m_wvalid stays 0, single s_b with resp 2'b11 and matching id.
- Mapped AR in flight, then unmapped AR -> DECERR beats appear only after the mapped rlast completes; beat count = len+1 and rlast on the final beat only.
- Issue 15 mapped writes with m_bready=0 -> 16th AW held at m_awvalid=1 with no m_aw handshake. Releasing one B admits it.
- Assert uncorersts during W_SINK -> next cycle all valids 0 and counters 0; a fresh mapped AW completes normally.

Source files
------------

// File: rtl/axi_remap_pkg.sv
// axi_remap_pkg: AXI response codes, remapper FSM states and the window match function
package axi_remap_pkg;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  typedef enum logic [1:0] {W_IDLE, W_FWD, W_SINK, W_ERRB} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_ERR} r_state_e;
  function automatic logic region_hit(input logic [63:0] addr, input logic [63:0] base, input logic [63:0] mask, input logic en);
    return en && ((addr & ~mask) == (base & ~mask));
  endfunction
endpackage

// File: rtl/axi_remap_slice.sv
// axi_remap_slice: one-entry valid/ready register; en gates upstream accept, m_ready frees the entry
module axi_remap_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         s_valid,
  input  logic [W-1:0] s_data,
  output logic         s_ready,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data
);
  logic full_q, full_d;
  logic [W-1:0] data_q, data_d;
  always_comb begin
    s_ready = en && (!full_q || m_ready);
    full_d = (s_valid && s_ready) || (full_q && !m_ready);
    data_d = s_valid && s_ready ? s_data : data_q;
    m_valid = full_q;
    m_data = data_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end
endmodule

// File: rtl/axi_addr_remapper.sv
// axi_addr_remapper: AXI4 core-to-SoC address remapper; cfg_* windows, s_axi_* from core, m_axi_* to SoC, unmapped bursts end in local DECERR
module axi_addr_remapper
  import axi_remap_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 64,
  parameter int ID_WIDTH    = 1,
  parameter int NUM_REGIONS = 4,
  parameter int OUTST_WIDTH = 4
) (
  input  logic                              uncoreclk,
  input  logic                              uncorersts,
  input  logic [NUM_REGIONS*ADDR_WIDTH-1:0] cfg_base,
  input  logic [NUM_REGIONS*ADDR_WIDTH-1:0] cfg_mask,
  input  logic [NUM_REGIONS*ADDR_WIDTH-1:0] cfg_target,
  input  logic [NUM_REGIONS-1:0]            cfg_en,
  input  logic [ID_WIDTH-1:0]               s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]             s_axi_awaddr,
  input  logic [7:0]                        s_axi_awlen,
  input  logic [2:0]                        s_axi_awsize,
  input  logic [1:0]                        s_axi_awburst,
  input  logic                              s_axi_awvalid,
  output logic                              s_axi_awready,
  input  logic [DATA_WIDTH-1:0]             s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]           s_axi_wstrb,
  input  logic                              s_axi_wlast,
  input  logic                              s_axi_wvalid,
  output logic                              s_axi_wready,
  output logic [ID_WIDTH-1:0]               s_axi_bid,
  output logic [1:0]                        s_axi_bresp,
  output logic                              s_axi_bvalid,
  input  logic                              s_axi_bready,
  input  logic [ID_WIDTH-1:0]               s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]             s_axi_araddr,
  input  logic [7:0]                        s_axi_arlen,
  input  logic [2:0]                        s_axi_arsize,
  input  logic [1:0]                        s_axi_arburst,
  input  logic                              s_axi_arvalid,
  output logic                              s_axi_arready,
  output logic [ID_WIDTH-1:0]               s_axi_rid,
  output logic [DATA_WIDTH-1:0]             s_axi_rdata,
  output logic [1:0]                        s_axi_rresp,
  output logic                              s_axi_rlast,
  output logic                              s_axi_rvalid,
  input  logic                              s_axi_rready,
  output logic [ID_WIDTH-1:0]               m_axi_awid,
  output logic [ADDR_WIDTH-1:0]             m_axi_awaddr,
  output logic [7:0]                        m_axi_awlen,
  output logic [2:0]                        m_axi_awsize,
  output logic [1:0]                        m_axi_awburst,
  output logic                              m_axi_awvalid,
  input  logic                              m_axi_awready,
  output logic [DATA_WIDTH-1:0]             m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]           m_axi_wstrb,
  output logic                              m_axi_wlast,
  output logic                              m_axi_wvalid,
  input  logic                              m_axi_wready,
  input  logic [ID_WIDTH-1:0]               m_axi_bid,
  input  logic [1:0]                        m_axi_bresp,
  input  logic                              m_axi_bvalid,
  output logic                              m_axi_bready,
  output logic [ID_WIDTH-1:0]               m_axi_arid,
  output logic [ADDR_WIDTH-1:0]             m_axi_araddr,
  output logic [7:0]                        m_axi_arlen,
  output logic [2:0]                        m_axi_arsize,
  output logic [1:0]                        m_axi_arburst,
  output logic                              m_axi_arvalid,
  input  logic                              m_axi_arready,
  input  logic [ID_WIDTH-1:0]               m_axi_rid,
  input  logic [DATA_WIDTH-1:0]             m_axi_rdata,
  input  logic [1:0]                        m_axi_rresp,
  input  logic                              m_axi_rlast,
  input  logic                              m_axi_rvalid,
  output logic                              m_axi_rready
);
  localparam int SW = ID_WIDTH + ADDR_WIDTH + 13;
  w_state_e w_q, w_d;
  r_state_e r_q, r_d;
  logic rdy_q, rdy_d;
  logic [ID_WIDTH-1:0] bid_q, bid_d, rid_q, rid_d;
  logic [7:0] rlen_q, rlen_d, beat_q, beat_d;
  logic [OUTST_WIDTH-1:0] wr_outst_q, wr_outst_d, rd_outst_q, rd_outst_d;
  logic [ADDR_WIDTH:0] aw_map, ar_map;
  logic aw_hs, ar_hs, aw_inc, ar_inc, b_dec, r_dec, wr_max, rd_max, b_own, r_own, r_last;
  function automatic logic [ADDR_WIDTH:0] remap(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] m, t;
    remap = {1'b0, a};
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      m = cfg_mask[i*ADDR_WIDTH +: ADDR_WIDTH];
      t = cfg_target[i*ADDR_WIDTH +: ADDR_WIDTH];
      if (region_hit(64'(a), 64'(cfg_base[i*ADDR_WIDTH +: ADDR_WIDTH]), 64'(m), cfg_en[i]))
        remap = {1'b1, (a & m) | (t & ~m)};
    end
  endfunction
  always_comb begin
    aw_map = remap(s_axi_awaddr);
    ar_map = remap(s_axi_araddr);
    wr_max = &wr_outst_q;
    rd_max = &rd_outst_q;
  end
  axi_remap_slice #(.W(SW)) u_aw (
    .clk     (uncoreclk),
    .rst     (uncorersts),
    .en      (rdy_q && w_q == W_IDLE),
    .s_valid (s_axi_awvalid && aw_map[ADDR_WIDTH]),
    .s_data  ({s_axi_awid, aw_map[ADDR_WIDTH-1:0], s_axi_awlen, s_axi_awsize, s_axi_awburst}),
    .s_ready (s_axi_awready),
    .m_valid (m_axi_awvalid),
    .m_ready (m_axi_awready && !wr_max),
    .m_data  ({m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst})
  );
  axi_remap_slice #(.W(SW)) u_ar (
    .clk     (uncoreclk),
    .rst     (uncorersts),
    .en      (rdy_q && r_q == R_IDLE),
    .s_valid (s_axi_arvalid && ar_map[ADDR_WIDTH]),
    .s_data  ({s_axi_arid, ar_map[ADDR_WIDTH-1:0], s_axi_arlen, s_axi_arsize, s_axi_arburst}),
    .s_ready (s_axi_arready),
    .m_valid (m_axi_arvalid),
    .m_ready (m_axi_arready && !rd_max),
    .m_data  ({m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst})
  );
  always_comb begin
    aw_hs = s_axi_awvalid && s_axi_awready;
    ar_hs = s_axi_arvalid && s_axi_arready;
    aw_inc = m_axi_awvalid && m_axi_awready && !wr_max;
    ar_inc = m_axi_arvalid && m_axi_arready && !rd_max;
    b_own = w_q == W_ERRB && wr_outst_q == '0;
    r_own = r_q == R_ERR;
    r_last = beat_q == rlen_q;
    m_axi_wvalid = w_q == W_FWD && s_axi_wvalid;
    s_axi_wready = w_q == W_SINK || (w_q == W_FWD && m_axi_wready);
    m_axi_wdata = s_axi_wdata;
    m_axi_wstrb = s_axi_wstrb;
    m_axi_wlast = s_axi_wlast;
    s_axi_bvalid = b_own || m_axi_bvalid;
    s_axi_bid = b_own ? bid_q : m_axi_bid;
    s_axi_bresp = b_own ? RESP_DECERR : m_axi_bresp;
    m_axi_bready = !b_own && s_axi_bready;
    s_axi_rvalid = r_own || m_axi_rvalid;
    s_axi_rid = r_own ? rid_q : m_axi_rid;
    s_axi_rdata = r_own ? '0 : m_axi_rdata;
    s_axi_rresp = r_own ? RESP_DECERR : m_axi_rresp;
    s_axi_rlast = r_own ? r_last : m_axi_rlast;
    m_axi_rready = !r_own && s_axi_rready;
    b_dec = m_axi_bvalid && m_axi_bready;
    r_dec = m_axi_rvalid && m_axi_rready && m_axi_rlast;
    wr_outst_d = wr_outst_q + OUTST_WIDTH'(aw_inc) - OUTST_WIDTH'(b_dec);
    rd_outst_d = rd_outst_q + OUTST_WIDTH'(ar_inc) - OUTST_WIDTH'(r_dec);
    rdy_d = 1'b1;
  end
  always_comb begin
    w_d = w_q;
    bid_d = bid_q;
    unique case (w_q)
      W_IDLE: if (aw_hs) begin
        w_d = aw_map[ADDR_WIDTH] ? W_FWD : W_SINK;
        bid_d = s_axi_awid;
      end
      W_FWD: if (s_axi_wvalid && s_axi_wready && s_axi_wlast) w_d = W_IDLE;
      W_SINK: if (s_axi_wvalid && s_axi_wlast) w_d = W_ERRB;
      default: if (b_own && s_axi_bready) w_d = W_IDLE;
    endcase
  end
  always_comb begin
    r_d = r_q;
    rid_d = rid_q;
    rlen_d = rlen_q;
    beat_d = beat_q;
    unique case (r_q)
      R_IDLE: if (ar_hs && !ar_map[ADDR_WIDTH]) begin
        r_d = R_WAIT;
        rid_d = s_axi_arid;
        rlen_d = s_axi_arlen;
        beat_d = '0;
      end
      R_WAIT: if (rd_outst_q == '0) r_d = R_ERR;
      default: if (s_axi_rready) begin
        beat_d = beat_q + 8'd1;
        r_d = r_last ? R_IDLE : R_ERR;
      end
    endcase
  end
  always_ff @(posedge uncoreclk) begin
    if (uncorersts) begin
      w_q <= W_IDLE;
      r_q <= R_IDLE;
      rdy_q <= 1'b0;
      bid_q <= '0;
      rid_q <= '0;
      rlen_q <= '0;
      beat_q <= '0;
      wr_outst_q <= '0;
      rd_outst_q <= '0;
    end else begin
      w_q <= w_d;
      r_q <= r_d;
      rdy_q <= rdy_d;
      bid_q <= bid_d;
      rid_q <= rid_d;
      rlen_q <= rlen_d;
      beat_q <= beat_d;
      wr_outst_q <= wr_outst_d;
      rd_outst_q <= rd_outst_d;
    end
  end
endmodule

// File: tb/tb_axi_addr_remapper.sv
// tb_axi_addr_remapper: directed checks of translation, DECERR completion, ordering, saturation and reset
module tb_axi_addr_remapper;
  localparam int AW = 32, DW = 64, IW = 1, NR = 4, OW = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic [NR*AW-1:0] cfg_base = '0, cfg_mask = '0, cfg_target = '0;
  logic [NR-1:0] cfg_en = '0;
  logic [IW-1:0] s_awid = '0, s_bid, s_arid = '0, s_rid, m_awid, m_bid = '0, m_arid, m_rid = '0;
  logic [AW-1:0] s_awaddr = '0, s_araddr = '0, m_awaddr, m_araddr;
  logic [7:0] s_awlen = '0, s_arlen = '0, m_awlen, m_arlen;
  logic [2:0] s_awsize = 3'd3, s_arsize = 3'd3, m_awsize, m_arsize;
  logic [1:0] s_awburst = 2'd1, s_arburst = 2'd1, m_awburst, m_arburst;
  logic [1:0] s_bresp, s_rresp, m_bresp = '0, m_rresp = '0;
  logic [DW-1:0] s_wdata = '0, m_wdata, s_rdata, m_rdata = '0;
  logic [DW/8-1:0] s_wstrb = '1, m_wstrb;
  logic s_awvalid = 0, s_awready, s_wlast = 0, s_wvalid = 0, s_wready, s_bvalid, s_bready = 1;
  logic s_arvalid = 0, s_arready, s_rlast, s_rvalid, s_rready = 1;
  logic m_awvalid, m_awready = 1, m_wlast, m_wvalid, m_wready = 1, m_bvalid = 0, m_bready;
  logic m_arvalid, m_arready = 1, m_rlast = 0, m_rvalid = 0, m_rready;
  int total = 0, bad = 0;

  axi_addr_remapper #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .NUM_REGIONS(NR), .OUTST_WIDTH(OW)) dut (
    .uncoreclk(clk), .uncorersts(rst),
    .cfg_base(cfg_base), .cfg_mask(cfg_mask), .cfg_target(cfg_target), .cfg_en(cfg_en),
    .s_axi_awid(s_awid), .s_axi_awaddr(s_awaddr), .s_axi_awlen(s_awlen), .s_axi_awsize(s_awsize),
    .s_axi_awburst(s_awburst), .s_axi_awvalid(s_awvalid), .s_axi_awready(s_awready),
    .s_axi_wdata(s_wdata), .s_axi_wstrb(s_wstrb), .s_axi_wlast(s_wlast), .s_axi_wvalid(s_wvalid), .s_axi_wready(s_wready),
    .s_axi_bid(s_bid), .s_axi_bresp(s_bresp), .s_axi_bvalid(s_bvalid), .s_axi_bready(s_bready),
    .s_axi_arid(s_arid), .s_axi_araddr(s_araddr), .s_axi_arlen(s_arlen), .s_axi_arsize(s_arsize),
    .s_axi_arburst(s_arburst), .s_axi_arvalid(s_arvalid), .s_axi_arready(s_arready),
    .s_axi_rid(s_rid), .s_axi_rdata(s_rdata), .s_axi_rresp(s_rresp), .s_axi_rlast(s_rlast),
    .s_axi_rvalid(s_rvalid), .s_axi_rready(s_rready),
    .m_axi_awid(m_awid), .m_axi_awaddr(m_awaddr), .m_axi_awlen(m_awlen), .m_axi_awsize(m_awsize),
    .m_axi_awburst(m_awburst), .m_axi_awvalid(m_awvalid), .m_axi_awready(m_awready),
    .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb), .m_axi_wlast(m_wlast), .m_axi_wvalid(m_wvalid), .m_axi_wready(m_wready),
    .m_axi_bid(m_bid), .m_axi_bresp(m_bresp), .m_axi_bvalid(m_bvalid), .m_axi_bready(m_bready),
    .m_axi_arid(m_arid), .m_axi_araddr(m_araddr), .m_axi_arlen(m_arlen), .m_axi_arsize(m_arsize),
    .m_axi_arburst(m_arburst), .m_axi_arvalid(m_arvalid), .m_axi_arready(m_arready),
    .m_axi_rid(m_rid), .m_axi_rdata(m_rdata), .m_axi_rresp(m_rresp), .m_axi_rlast(m_rlast),
    .m_axi_rvalid(m_rvalid), .m_axi_rready(m_rready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_mapped(input string tag, input logic [31:0] a, input logic [31:0] exp);
    cyc();
    s_awvalid = 1; s_awaddr = a; s_awid = 1; s_awlen = 0;
    #1 chk({tag, "_awrdy"}, s_awready, 1);
    cyc();
    s_awvalid = 0; s_wvalid = 1; s_wlast = 1; s_wdata = {32'hA5A5_0000, a};
    #1 chk({tag, "_awv"}, m_awvalid, 1);
    chk({tag, "_awaddr"}, m_awaddr, exp);
    chk({tag, "_wv"}, m_wvalid, 1);
    chk({tag, "_wdata"}, m_wdata, {32'hA5A5_0000, a});
    cyc();
    s_wvalid = 0; s_wlast = 0; m_bvalid = 1; m_bid = 1; m_bresp = 2'b01;
    #1 chk({tag, "_bv"}, s_bvalid, 1);
    chk({tag, "_bresp"}, s_bresp, 2'b01);
    chk({tag, "_bid"}, s_bid, 1);
    cyc();
    m_bvalid = 0; m_bid = 0; m_bresp = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    repeat (2) cyc();
    #1 chk("rst_awrdy", s_awready, 0);
    chk("rst_arrdy", s_arready, 0);
    chk("rst_awv", m_awvalid, 0);
    chk("rst_arv", m_arvalid, 0);
    chk("rst_bv", s_bvalid, 0);
    chk("rst_rv", s_rvalid, 0);
    rst = 0;
    cyc();
    #1 chk("up_awrdy", s_awready, 1);
    chk("up_arrdy", s_arready, 1);

    cfg_mask[31:0] = 32'h0FFF_FFFF; cfg_target[31:0] = 32'h1000_0000; cfg_en = 4'b0001;
    cyc();
    s_arvalid = 1; s_araddr = 32'h0000_1000; s_arlen = 3; s_arid = 1;
    #1 chk("ar_rdy", s_arready, 1);
    chk("ar_early", m_arvalid, 0);
    cyc();
    s_arvalid = 0;
    #1 chk("ar_v", m_arvalid, 1);
    chk("ar_addr", m_araddr, 32'h1000_1000);
    chk("ar_len", m_arlen, 3);
    chk("ar_id", m_arid, 1);
    for (int k = 0; k < 4; k++) begin
      cyc();
      m_rvalid = 1; m_rid = 1; m_rdata = 64'hD0 + 64'(k); m_rlast = k == 3; m_rresp = 0;
      #1 chk("r_data", s_rdata, 64'hD0 + 64'(k));
      chk("r_last", s_rlast, k == 3);
      chk("r_rdy", m_rready, 1);
    end
    cyc();
    m_rvalid = 0; m_rlast = 0;
    #1 chk("r_end", s_rvalid, 0);
    chk("ar_gone", m_arvalid, 0);

    cfg_base[31:0] = 32'h2000_0000; cfg_mask[31:0] = 32'h0000_FFFF; cfg_target[31:0] = 32'h8000_0000;
    cfg_base[63:32] = 32'h2000_0000; cfg_mask[63:32] = 32'h00FF_FFFF; cfg_target[63:32] = 32'h9000_0000;
    cfg_en = 4'b0011;
    wr_mapped("ovl0", 32'h2000_3456, 32'h8000_3456);
    cfg_en = 4'b0010;
    wr_mapped("ovl1", 32'h2000_3456, 32'h9000_3456);

    cfg_base = '0; cfg_mask = '0; cfg_target = '0;
    cfg_mask[31:0] = 32'h0FFF_FFFF; cfg_target[31:0] = 32'h1000_0000; cfg_en = 4'b0001;
    cyc();
    s_awvalid = 1; s_awaddr = 32'h5000_0000; s_awid = 1; s_awlen = 7;
    #1 chk("sink_awrdy", s_awready, 1);
    for (int k = 0; k < 8; k++) begin
      cyc();
      s_awvalid = 0; s_wvalid = 1; s_wlast = k == 7;
      #1 chk("sink_wrdy", s_wready, 1);
      chk("sink_mwv", m_wvalid, 0);
      chk("sink_bv", s_bvalid, 0);
    end
    cyc();
    s_wvalid = 0; s_wlast = 0;
    #1 chk("errb_v", s_bvalid, 1);
    chk("errb_id", s_bid, 1);
    chk("errb_resp", s_bresp, 2'b11);
    chk("errb_mbrdy", m_bready, 0);
    cyc();
    #1 chk("errb_once", s_bvalid, 0);
    chk("errb_awrdy", s_awready, 1);

    cyc();
    s_arvalid = 1; s_araddr = 32'h0000_2000; s_arlen = 1; s_arid = 0;
    #1 chk("ord_rdy1", s_arready, 1);
    cyc();
    s_araddr = 32'h7000_0000; s_arlen = 2; s_arid = 1;
    #1 chk("ord_rdy2", s_arready, 1);
    chk("ord_mv", m_arvalid, 1);
    chk("ord_maddr", m_araddr, 32'h1000_2000);
    cyc();
    s_arvalid = 0;
    #1 chk("ord_wait_rv", s_rvalid, 0);
    chk("ord_wait_rdy", s_arready, 0);
    cyc();
    #1 chk("ord_wait_rv2", s_rvalid, 0);
    for (int k = 0; k < 2; k++) begin
      cyc();
      m_rvalid = 1; m_rid = 0; m_rdata = 64'hE0 + 64'(k); m_rlast = k == 1; m_rresp = 0;
      #1 chk("ord_mdata", s_rdata, 64'hE0 + 64'(k));
      chk("ord_mresp", s_rresp, 0);
    end
    cyc();
    m_rvalid = 0; m_rlast = 0;
    #1 chk("ord_gap", s_rvalid, 0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      #1 chk("err_rv", s_rvalid, 1);
      chk("err_resp", s_rresp, 2'b11);
      chk("err_data", s_rdata, 0);
      chk("err_id", s_rid, 1);
      chk("err_last", s_rlast, k == 2);
      chk("err_mrrdy", m_rready, 0);
    end
    cyc();
    #1 chk("err_done", s_rvalid, 0);
    chk("err_arrdy", s_arready, 1);

    s_bready = 0;
    for (int k = 0; k < 16; k++) begin
      cyc();
      s_wvalid = 0; s_wlast = 0; s_awvalid = 1; s_awaddr = 32'(k) << 4; s_awid = 0; s_awlen = 0;
      #1 chk("sat_awrdy_in", s_awready, 1);
      cyc();
      s_awvalid = 0; s_wvalid = 1; s_wlast = 1;
    end
    cyc();
    s_wvalid = 0; s_wlast = 0;
    #1 chk("sat_held", m_awvalid, 1);
    chk("sat_addr", m_awaddr, 32'h1000_00F0);
    chk("sat_blocked", s_awready, 0);
    cyc();
    #1 chk("sat_held2", m_awvalid, 1);
    cyc();
    m_bvalid = 1; m_bid = 0; m_bresp = 0; s_bready = 1;
    #1 chk("sat_b", s_bvalid, 1);
    cyc();
    m_bvalid = 0;
    #1 chk("sat_admit", m_awvalid, 1);
    cyc();
    #1 chk("sat_drained", m_awvalid, 0);
    chk("sat_awrdy", s_awready, 1);

    cyc();
    s_awvalid = 1; s_awaddr = 32'h5000_0000; s_awid = 1; s_awlen = 3;
    cyc();
    s_awvalid = 0; s_wvalid = 1; s_wlast = 0;
    #1 chk("mid_sink", s_wready, 1);
    cyc();
    rst = 1; s_wvalid = 0;
    cyc();
    rst = 0;
    #1 chk("mid_awrdy", s_awready, 0);
    chk("mid_awv", m_awvalid, 0);
    chk("mid_arv", m_arvalid, 0);
    chk("mid_bv", s_bvalid, 0);
    chk("mid_rv", s_rvalid, 0);
    chk("mid_wrdy", s_wready, 0);
    wr_mapped("post", 32'h0000_4444, 32'h1000_4444);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
